image_ram_arbiter: RTL and testbench
====================================

IMAGE_RAM_ARBITER -- requirements
Module: image_ram_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, default 12, image RAM address width.
REQ-002 Parameter: DATA_WIDTH, default 8, image RAM data width.
REQ-003 Port: clk  input  1  single clock, all state on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: req  input  3  per-requester access request; bit 0 UART loader, bit 1 decoder, bit 2 UART readback.
REQ-006 Port: lock  input  3  per-requester request to keep ownership after its current access.
REQ-007 Port: we  input  3  per-requester write enable (1 write, 0 read).
REQ-008 Port: addr  input  3*ADDR_WIDTH  per-requester address; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 Port: wdata  input  3*DATA_WIDTH  per-requester write data, packed like addr.
REQ-010 Port: gnt  output  3  one-hot-or-zero grant, combinational.
REQ-011 Port: rvalid  output  3  per-requester read-data-valid strobe, one cycle.
REQ-012 Port: rdata  output  DATA_WIDTH  shared read data, direct pass-through of ram_rdata.
REQ-013 Port: ram_en  output  1  registered RAM enable.
REQ-014 Port: ram_we  output  1  registered RAM write enable.
REQ-015 Port: ram_addr  output  ADDR_WIDTH  registered RAM address.
REQ-016 Port: ram_wdata  output  DATA_WIDTH  registered RAM write data.
REQ-017 Port: ram_rdata  input  DATA_WIDTH  synchronous-read RAM output, valid the cycle after the RAM samples ram_en=1, we=0.

Function
REQ-018 Handshake: access of requester i is accepted on a rising edge where req[i]=1 and gnt[i]=1; requester holds addr/we/wdata stable while req[i]=1 and gnt[i]=0.
REQ-019 At most one gnt bit high per cycle; gnt[i] only high when req[i]=1.
REQ-020 State machine, two states: ARB and LOCKED (owner register, 2 bits).
REQ-021 ARB: gnt goes to first requesting index at or after round-robin pointer rr, scanning rr, rr+1, rr+2 modulo 3.
REQ-022 On each accepted access in ARB by requester i, rr becomes (i+1) mod 3, wrapping 2 -> 0; with no accept rr holds.
REQ-023 ARB -> LOCKED when the accepted requester has lock[i]=1 on the accepting edge; owner <= i.
REQ-024 LOCKED: only owner may be granted (gnt[owner]=req[owner]); other requests wait, rr unchanged.
REQ-025 LOCKED -> ARB on any edge where lock[owner]=0; that cycle behaves as LOCKED (owner may still complete an access), and rr <= (owner+1) mod 3.
REQ-026 Each accepted access registers ram_en=1, ram_we=we[i], ram_addr, ram_wdata from requester i on the accepting edge; cycles without accept register ram_en=0, ram_we=0, addr/wdata hold.
REQ-027 Throughput: one access per cycle, back-to-back accepts allowed for same or different requesters.
REQ-028 Read latency: read accepted on edge E0 -> ram_en in cycle E0..E1 -> rvalid[i]=1 with rdata valid in cycle E1..E2 (exactly 2 cycles after accept); tag pipeline carries index.
REQ-029 Writes never produce rvalid.
REQ-030 Read and write to same address in consecutive accepts: RAM order preserved; arbiter adds no forwarding.

Reset
REQ-031 While rst=0: gnt=0, rvalid=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, rr=0, state ARB, owner=0, read tag pipeline cleared.
REQ-032 Reset asserted mid-read: pending rvalid never appears after release; first cycle after release behaves as fresh ARB with rr=0.

Verification
REQ-033 Single read: req=3'b010, we=0, addr1=0x005 -> gnt=3'b010 same cycle; ram_en=1, ram_addr=0x005 next cycle; rvalid=3'b010, rdata=RAM[5] 2 cycles after accept.
REQ-034 Round-robin: req=3'b111 held, no lock -> grant order 0,1,2,0,1,2 on consecutive cycles, ram_en=1 every cycle.
REQ-035 Lock: requester 1 writes 4 bytes 0xA0..0xA3 to 0x010..0x013 with lock=1 on first three, 0 on last, while req[0], req[2] high -> gnt stays 3'b010 four cycles, then gnt=3'b100 (rr=2).
REQ-036 Idle/wrap: single accept by requester 2, then req=3'b001 -> rr wraps to 0, requester 0 granted; with req=0 ram_en=0 and rr unchanged.
REQ-037 Reset mid-read: read accepted, rst=0 for one cycle next -> rvalid=0 throughout and after release, all outputs at REQ-031 values.

Source files
------------

// File: rtl/image_ram_arbiter.sv
// Three-way image RAM arbiter: round-robin with a lock that holds one owner; registered RAM port.
// Grant is combinational; a read returns rvalid two cycles after accept; losers hold their request.
module image_ram_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              req,
  input  logic [2:0]              lock,
  input  logic [2:0]              we,
  input  logic [3*ADDR_WIDTH-1:0] addr,
  input  logic [3*DATA_WIDTH-1:0] wdata,
  output logic [2:0]              gnt,
  output logic [2:0]              rvalid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t     state, state_nxt;
  logic [1:0] owner, owner_nxt;
  logic [1:0] rr, rr_nxt;
  logic [1:0] sel, cand;
  logic       acc;
  logic [2:0] rd_tag;

  function automatic logic [1:0] add3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr;
    sel       = 2'd0;
    cand      = 2'd0;
    acc       = 1'b0;
    if (state == ARB) begin
      for (int k = 0; k < 3; k++) begin
        cand = add3(rr, 2'(k));
        if (!acc && req[cand]) begin
          acc = 1'b1;
          sel = cand;
        end
      end
      if (acc) begin
        rr_nxt = add3(sel, 2'd1);
        if (lock[sel]) begin
          state_nxt = LOCKED;
          owner_nxt = sel;
        end
      end
    end else begin
      // The releasing cycle still serves the owner; rr resumes just after it.
      sel = owner;
      acc = req[owner];
      if (!lock[owner]) begin
        state_nxt = ARB;
        rr_nxt    = add3(owner, 2'd1);
      end
    end
    acc = acc & rst;
  end

  assign gnt   = acc ? (3'b001 << sel) : 3'b000;
  assign rdata = ram_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ARB;
      owner     <= 2'd0;
      rr        <= 2'd0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rd_tag    <= 3'b000;
      rvalid    <= 3'b000;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr     <= rr_nxt;
      ram_en <= acc;
      ram_we <= acc & we[sel];
      if (acc) begin
        ram_addr  <= addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
        ram_wdata <= wdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
      end
      rd_tag <= (acc && !we[sel]) ? gnt : 3'b000;
      rvalid <= rd_tag;
    end
  end

endmodule

// File: tb/tb_image_ram_arbiter.sv
// Directed bench for image_ram_arbiter with a synchronous-read RAM model behind it.
module tb_image_ram_arbiter;
  localparam int AW = 12;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      req, lock, we;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic            ram_en, ram_we;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic [DW-1:0]   ram_rdata;

  int n_cmp = 0;
  int n_err = 0;

  // Unwritten locations read as (low address byte + 0x30).
  logic [DW-1:0] mem    [0:(1<<AW)-1];
  bit            mem_wr [0:(1<<AW)-1];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr]    <= ram_wdata;
        mem_wr[ram_addr] <= 1'b1;
      end else begin
        ram_rdata <= mem_wr[ram_addr] ? mem[ram_addr] : 8'(ram_addr) + 8'h30;
      end
    end
  end

  image_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] rr_gnt [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [7:0] rr_rd  [6] = '{8'h30, 8'h31, 8'h32, 8'h30, 8'h31, 8'h32};
  logic [11:0] rr_ad [6] = '{12'h100, 12'h101, 12'h102, 12'h100, 12'h101, 12'h102};

  initial begin
    rst = 1'b0; req = 3'b000; lock = 3'b000; we = 3'b000; addr = '0; wdata = '0;
    tick();
    tick();
    req = 3'b111;
    #1;
    chk("reset_gnt", 32'(gnt), 32'h0);
    req = 3'b000;
    chk("reset_rvalid", 32'(rvalid), 32'h0);
    chk("reset_ram_en", 32'(ram_en), 32'h0);
    chk("reset_ram_we", 32'(ram_we), 32'h0);
    chk("reset_ram_addr", 32'(ram_addr), 32'h0);
    chk("reset_ram_wdata", 32'(ram_wdata), 32'h0);
    rst = 1'b1;

    // Round-robin with all three requesting reads back to back.
    req = 3'b111; we = 3'b000; addr = {12'h102, 12'h101, 12'h100};
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_gnt", 32'(gnt), 32'(rr_gnt[k]));
      tick();
      chk("rr_ram_en", 32'(ram_en), 32'h1);
      chk("rr_ram_addr", 32'(ram_addr), 32'(rr_ad[k]));
      if (k >= 1) begin
        chk("rr_rvalid", 32'(rvalid), 32'(rr_gnt[k-1]));
        chk("rr_rdata", 32'(rdata), 32'(rr_rd[k-1]));
      end
    end
    req = 3'b000;
    tick();
    chk("rr_tail_rvalid", 32'(rvalid), 32'h4);
    chk("rr_tail_rdata", 32'(rdata), 32'h32);
    chk("idle_ram_en", 32'(ram_en), 32'h0);
    chk("idle_addr_hold", 32'(ram_addr), 32'h102);
    tick();
    chk("rr_drain_rvalid", 32'(rvalid), 32'h0);

    // Single read by requester 1 (rr = 0).
    req = 3'b010; addr = {12'h000, 12'h005, 12'h000};
    #1;
    chk("rd1_gnt", 32'(gnt), 32'h2);
    tick();
    req = 3'b000;
    chk("rd1_ram_en", 32'(ram_en), 32'h1);
    chk("rd1_ram_addr", 32'(ram_addr), 32'h005);
    chk("rd1_ram_we", 32'(ram_we), 32'h0);
    chk("rd1_rvalid_early", 32'(rvalid), 32'h0);
    tick();
    chk("rd1_rvalid", 32'(rvalid), 32'h2);
    chk("rd1_rdata", 32'(rdata), 32'h35);
    chk("rd1_ram_en_off", 32'(ram_en), 32'h0);

    // rr = 2: requester 2, then wrap to requester 0, then idle.
    req = 3'b100; addr = {12'h007, 12'h005, 12'h009};
    #1;
    chk("wrap_gnt2", 32'(gnt), 32'h4);
    tick();
    req = 3'b001;
    #1;
    chk("wrap_gnt0", 32'(gnt), 32'h1);
    tick();
    req = 3'b000;
    chk("wrap_ram_addr", 32'(ram_addr), 32'h009);
    chk("wrap_rvalid2", 32'(rvalid), 32'h4);
    chk("wrap_rdata2", 32'(rdata), 32'h37);
    tick();
    chk("wrap_idle_en", 32'(ram_en), 32'h0);
    chk("wrap_idle_addr", 32'(ram_addr), 32'h009);
    chk("wrap_rvalid0", 32'(rvalid), 32'h1);
    chk("wrap_rdata0", 32'(rdata), 32'h39);
    tick();
    chk("idle2_ram_en", 32'(ram_en), 32'h0);
    req = 3'b111;
    #1;
    chk("rr_held_gnt", 32'(gnt), 32'h2);

    // Locked burst of writes by requester 1 while 0 and 2 keep requesting.
    we = 3'b010;
    for (int j = 0; j < 4; j++) begin
      addr  = {12'h002, 12'(12'h010 + j), 12'h001};
      wdata = {8'h00, 8'(8'hA0 + j), 8'h00};
      lock  = (j < 3) ? 3'b010 : 3'b000;
      #1;
      chk("lock_gnt", 32'(gnt), 32'h2);
      tick();
      chk("lock_ram_we", 32'(ram_we), 32'h1);
      chk("lock_ram_addr", 32'(ram_addr), 32'(12'h010 + j));
      chk("lock_ram_wdata", 32'(ram_wdata), 32'(8'hA0 + j));
    end
    lock = 3'b000; we = 3'b000;
    #1;
    chk("unlock_gnt", 32'(gnt), 32'h4);
    chk("write_no_rvalid", 32'(rvalid), 32'h0);
    req = 3'b001; addr = {12'h000, 12'h000, 12'h012};
    #1;
    chk("rdback_gnt", 32'(gnt), 32'h1);
    tick();
    req = 3'b000;
    tick();
    chk("rdback_rvalid", 32'(rvalid), 32'h1);
    chk("rdback_rdata", 32'(rdata), 32'hA2);

    // Reset lands right after a read is accepted (rr = 1 before reset).
    req = 3'b001; addr = {12'h000, 12'h000, 12'h005};
    #1;
    chk("mid_gnt", 32'(gnt), 32'h1);
    tick();
    rst = 1'b0; req = 3'b100;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_ram_en", 32'(ram_en), 32'h0);
    chk("mid_rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("mid_rst_rvalid", 32'(rvalid), 32'h0);
    tick();
    chk("mid_rst_rvalid2", 32'(rvalid), 32'h0);
    rst = 1'b1; req = 3'b000;
    tick();
    chk("post_rst_rvalid", 32'(rvalid), 32'h0);
    chk("post_rst_ram_en", 32'(ram_en), 32'h0);
    tick();
    chk("post_rst_rvalid2", 32'(rvalid), 32'h0);
    req = 3'b111;
    #1;
    chk("post_rst_gnt", 32'(gnt), 32'h1);
    req = 3'b000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
